// File: rtl/arm_instr_encoder.sv
// Encodes structured ARM instruction descriptors into 32-bit words and streams
// them into IMEM through a registered write port, one word per legal accept.
module arm_instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [3:0]        in_cond,
  input  logic              in_imm,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic              in_load,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [3:0]        in_rs,
  input  logic [2:0]        in_shtype,
  input  logic [4:0]        in_shamt,
  input  logic              in_regshift,
  input  logic [23:0]       in_immval,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        err_count,
  output logic              err,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = (ADDR_W + 1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [7:0]          ec_q, ec_d;
  logic                err_q, err_d;

  // Encoder datapath (purely combinational on the descriptor fields).
  logic        is_dp, is_mem, is_rrx;
  logic [1:0]  sh2;
  logic [4:0]  shamt_e;
  logic [11:0] reg_off;
  logic [11:0] dp_op2;
  logic        s_eff;
  logic [3:0]  rn_eff;
  logic        illegal;
  logic [31:0] enc_word;
  logic        accept;

  always_comb begin
    is_dp   = (in_class == 2'b00);
    is_mem  = (in_class == 2'b01);
    is_rrx  = (in_shtype == 3'd4);
    // RRX is the ROR encoding with a zero shift amount.
    sh2     = is_rrx ? 2'b11 : in_shtype[1:0];
    shamt_e = is_rrx ? 5'd0 : in_shamt;
    reg_off = {shamt_e, sh2, 1'b0, in_rm};
    if (in_imm)
      dp_op2 = in_immval[11:0];
    else if (in_regshift)
      dp_op2 = {in_rs, 1'b0, sh2, 1'b1, in_rm};
    else
      dp_op2 = reg_off;
    s_eff  = in_s | (in_cmd[3:2] == 2'b10);
    rn_eff = ((in_cmd[3:2] == 2'b11) && in_cmd[0]) ? 4'd0 : in_rn;

    illegal = (in_cond == 4'hF)
            | (is_dp & ~in_imm & in_regshift & is_rrx)
            | (((is_dp & ~in_imm & ~in_regshift) | (is_mem & ~in_imm))
               & (in_shtype == 3'd3) & (in_shamt == 5'd0))
            | (is_mem & in_regshift)
            | (is_mem & ~in_imm & is_rrx);

    case (in_class)
      2'b00:   enc_word = {in_cond, 2'b00, in_imm, in_cmd, s_eff, rn_eff, in_rd, dp_op2};
      2'b01:   enc_word = {in_cond, 2'b01, ~in_imm, 1'b1, 1'b1, 1'b0, 1'b0, in_load,
                           in_rn, in_rd, in_imm ? in_immval[11:0] : reg_off};
      default: enc_word = {in_cond, 3'b101, in_class[0], in_immval};
    endcase
  end

  // Handshake: a descriptor is consumed on a rising edge where in_valid and
  // in_ready are both high; in_ready holds only in LOAD with space left.
  assign in_ready = (state_q == S_LOAD) && (addr_q < DEPTH_W);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ec_d    = ec_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          ec_d    = 8'd0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (illegal) begin
            if (ec_q != 8'hFF) ec_d = ec_q + 8'd1;
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q[ADDR_W-1:0];
            wdata_d = enc_word;
            addr_d  = addr_q + 1'b1;
            if (addr_q == LAST_W) state_d = S_DONE;
          end
        end
        if (finish) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      ec_q    <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ec_q    <= ec_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign word_count = addr_q;
  assign err_count  = ec_q;
  assign err        = err_q;
  assign done       = (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Directed bench for arm_instr_encoder with a 4-word session (DEPTH = 4).
module tb_arm_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_class = '0;
  logic [3:0]        in_cond = '0;
  logic              in_imm = 1'b0;
  logic [3:0]        in_cmd = '0;
  logic              in_s = 1'b0;
  logic              in_load = 1'b0;
  logic [3:0]        in_rd = '0;
  logic [3:0]        in_rn = '0;
  logic [3:0]        in_rm = '0;
  logic [3:0]        in_rs = '0;
  logic [2:0]        in_shtype = '0;
  logic [4:0]        in_shamt = '0;
  logic              in_regshift = 1'b0;
  logic [23:0]       in_immval = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        err_count;
  logic              err;
  logic              done;
  logic [1:0]        dbg_state;

  int checks = 0;
  int failures = 0;

  arm_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_cond(in_cond), .in_imm(in_imm), .in_cmd(in_cmd), .in_s(in_s),
    .in_load(in_load), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_rs(in_rs), .in_shtype(in_shtype), .in_shamt(in_shamt),
    .in_regshift(in_regshift), .in_immval(in_immval),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .err_count(err_count), .err(err),
    .done(done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cls, input logic [3:0] cond, input logic imm,
                       input logic [3:0] cmd, input logic s, input logic ld,
                       input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                       input logic [3:0] rs, input logic [2:0] sh, input logic [4:0] shamt,
                       input logic rsh, input logic [23:0] immval);
    in_class = cls; in_cond = cond; in_imm = imm; in_cmd = cmd; in_s = s;
    in_load = ld; in_rd = rd; in_rn = rn; in_rm = rm; in_rs = rs;
    in_shtype = sh; in_shamt = shamt; in_regshift = rsh; in_immval = immval;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept_write(input string tag, input logic [31:0] exp_addr,
                              input logic [31:0] exp_data, input logic [31:0] exp_wc);
    in_valid = 1'b1;
    wait_ready(tag);
    tick();
    in_valid = 1'b0;
    check({tag, "_we"}, 32'(imem_we), 32'd1);
    check({tag, "_addr"}, 32'(imem_addr), exp_addr);
    check({tag, "_data"}, imem_wdata, exp_data);
    check({tag, "_wc"}, 32'(word_count), exp_wc);
  endtask

  task automatic accept_reject(input string tag, input logic [31:0] exp_ec,
                               input logic [31:0] exp_wc);
    in_valid = 1'b1;
    wait_ready(tag);
    tick();
    in_valid = 1'b0;
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_ec"}, 32'(err_count), exp_ec);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_wc"}, 32'(word_count), exp_wc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_data"}, imem_wdata, 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
    check({tag, "_ec"}, 32'(err_count), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(); tick();
    check_reset_values("rst");
    reset = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd0);

    // session 1: DP forms, error accounting, final-address stop
    pulse_start();
    check("s1_ready", 32'(in_ready), 32'd1);
    drive(2'b00, 4'hE, 1'b1, 4'h4, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 3'd0, 5'd0, 1'b0, 24'h000005);
    accept_write("add_imm", 0, 32'hE2821005, 1);
    tick();
    check("we_pulse", 32'(imem_we), 32'd0);
    drive(2'b00, 4'hE, 1'b0, 4'h2, 1'b1, 1'b0, 4'd3, 4'd4, 4'd5, 4'd0, 3'd0, 5'd2, 1'b0, 24'h0);
    accept_write("subs_lsl", 1, 32'hE0543105, 2);
    drive(2'b00, 4'hE, 1'b1, 4'hA, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 5'd0, 1'b0, 24'h0);
    accept_write("cmp_imm", 2, 32'hE3500000, 3);
    drive(2'b00, 4'hE, 1'b0, 4'h4, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 3'd4, 5'd0, 1'b1, 24'h0);
    accept_reject("rsh_rrx", 1, 3);
    drive(2'b00, 4'hF, 1'b1, 4'h4, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 3'd0, 5'd0, 1'b0, 24'h5);
    accept_reject("cond_f", 2, 3);
    drive(2'b01, 4'hE, 1'b1, 4'h0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 3'd0, 5'd0, 1'b0, 24'h000004);
    accept_write("ldr_imm", 3, 32'hE5910004, 4);
    check("s1_done", 32'(done), 32'd1);
    check("s1_ready_low", 32'(in_ready), 32'd0);
    check("s1_err_kept", 32'(err_count), 32'd2);

    // session 2: MEM store, BL, MOV Rn forcing, register-shifted register
    pulse_start();
    check("s2_wc", 32'(word_count), 32'd0);
    check("s2_ec", 32'(err_count), 32'd0);
    check("s2_err", 32'(err), 32'd0);
    check("s2_done", 32'(done), 32'd0);
    drive(2'b01, 4'hE, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 3'd0, 5'd0, 1'b0, 24'h000008);
    accept_write("str_imm", 0, 32'hE5810008, 1);
    drive(2'b11, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 5'd0, 1'b0, 24'h000010);
    accept_write("bl", 1, 32'hEB000010, 2);
    drive(2'b00, 4'hE, 1'b1, 4'hD, 1'b0, 1'b0, 4'd7, 4'd5, 4'd0, 4'd0, 3'd0, 5'd0, 1'b0, 24'h0000FF);
    accept_write("mov_imm", 2, 32'hE3A070FF, 3);
    drive(2'b00, 4'hE, 1'b0, 4'h4, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 3'd0, 5'd0, 1'b1, 24'h0);
    accept_write("add_rsr", 3, 32'hE0821413, 4);
    check("s2_done_end", 32'(done), 32'd1);

    // session 3: five back-to-back valids against a 4-word session
    pulse_start();
    drive(2'b00, 4'hE, 1'b0, 4'hD, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 3'd4, 5'd0, 1'b0, 24'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_rd = 4'(i);
      check($sformatf("b2b_ready%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
      if (i < 4) begin
        check($sformatf("b2b_we%0d", i), 32'(imem_we), 32'd1);
        check($sformatf("b2b_addr%0d", i), 32'(imem_addr), 32'(i));
        check($sformatf("b2b_data%0d", i), imem_wdata, 32'hE1A00061 | (32'(i) << 12));
      end else begin
        check("b2b_fifth_we", 32'(imem_we), 32'd0);
        check("b2b_fifth_wc", 32'(word_count), 32'd4);
        check("b2b_done", 32'(done), 32'd1);
      end
    end
    in_valid = 1'b0;

    // start+finish in DONE: start wins; then finish with a same-cycle accept
    start = 1'b1; finish = 1'b1;
    tick();
    start = 1'b0; finish = 1'b0;
    check("sf_done", 32'(done), 32'd0);
    check("sf_ready", 32'(in_ready), 32'd1);
    check("sf_wc", 32'(word_count), 32'd0);
    drive(2'b01, 4'hE, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd2, 4'd0, 3'd0, 5'd2, 1'b0, 24'h0);
    finish = 1'b1;
    accept_write("ldr_reg_fin", 0, 32'hE7910102, 1);
    finish = 1'b0;
    check("fin_done", 32'(done), 32'd1);
    check("fin_ready", 32'(in_ready), 32'd0);

    // remaining illegal forms; start inside LOAD must not clear counters
    pulse_start();
    drive(2'b00, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd0, 3'd3, 5'd0, 1'b0, 24'h0);
    accept_reject("ror0", 1, 0);
    drive(2'b01, 4'hE, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 3'd0, 5'd0, 1'b1, 24'h0);
    accept_reject("mem_rsh", 2, 0);
    drive(2'b01, 4'hE, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd2, 4'd0, 3'd4, 5'd0, 1'b0, 24'h0);
    accept_reject("mem_rrx", 3, 0);
    pulse_start();
    check("ld_start_ec", 32'(err_count), 32'd3);
    check("ld_start_ready", 32'(in_ready), 32'd1);

    // reset with a write pending on the port
    drive(2'b00, 4'hE, 1'b1, 4'h4, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 3'd0, 5'd0, 1'b0, 24'h000005);
    accept_write("pre_rst", 0, 32'hE2821005, 1);
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    tick();
    reset = 1'b1;
    tick(); tick();
    check("post_rst_ready", 32'(in_ready), 32'd0);
    check("post_rst_we", 32'(imem_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
- Converts structured instruction descriptors (the same field set our decoder consumes) into 32-bit ARM words and streams them into instruction memory through a write port.
- Used by the boot/test loader to build programs in IMEM. It has a valid/ready input handshake, a one-stage encode pipeline, a write-address counter with a full stop, and error accounting for descriptors that cannot be encoded.

Parameters:
- ADDR_W, 6, width of the IMEM word address.
- DEPTH, 64, number of words the encoder may write per load session (≤ 2^ADDR_W).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a load session at address 0 (honoured in IDLE/DONE only).
- finish  input  1  pulse; ends the session early (honoured in LOAD).
- in_valid  input  1  descriptor valid.
- in_ready  output  1  encoder accepts a descriptor this cycle.
- in_class  input  2  00 DP, 01 LDR/STR, 10 B, 11 BL.
- in_cond  input  4  condition field.
- in_imm  input  1  DP: I bit; MEM: 1 = immediate offset.
- in_cmd  input  4  DP opcode (AND..MVN; 0xD = MOV).
- in_s  input  1  DP S bit.
- in_load  input  1  MEM: 1 = LDR, 0 = STR.
- in_rd, in_rn, in_rm, in_rs  input  4 each  register fields.
- in_shtype  input  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX.
- in_shamt  input  5  immediate shift amount.
- in_regshift  input  1  DP register-shifted-register form.
- in_immval  input  24  DP: rot4:imm8 in [11:0]; MEM: imm12 in [11:0]; B/BL: imm24.
- imem_we  output  1  write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  32  encoded word.
- word_count  output  ADDR_W+1  words written this session.
- err_count  output  8  rejected descriptors this session (saturates at 255).
- err  output  1  sticky; set on any rejection.
- done  output  1  high in DONE.

Behaviour:
- FSM states IDLE, LOAD, DONE. Reset enters IDLE.
- Reset values: imem_we = 0, imem_addr = 0, imem_wdata = 0, word_count = 0, err_count = 0, err = 0, done = 0, in_ready = 0.
- IDLE, start → LOAD. On that transition: address, word_count, err_count and err are cleared.
- LOAD: in_ready = 1 while address < DEPTH.
- Acceptance occurs when in_valid & in_ready.
- The encoded word is registered and written the following cycle (latency 1): imem_we pulses one cycle with imem_addr = the address at accept. Address and word_count increment on each legal accept.
- The accept that consumes address DEPTH-1 moves the FSM to DONE. in_ready drops the next cycle; the final write still occurs.
- finish in LOAD → DONE. An accept in the same cycle is still written. finish has priority over a later accept.
- DONE: done = 1. start → LOAD (counters cleared). start in LOAD is ignored.
- DP encoding:
  - [31:28] cond, [27:26] 00, [25] I, [24:21] cmd, [20] S, [19:16] Rn, [15:12] Rd.
  - S is forced to 1 for cmd 8–B (TST/TEQ/CMP/CMN). Rn is forced to 0 for cmd 0xD and 0xF.
  - [11:0] when I = 1: immval[11:0].
  - [11:0] when I = 0 and regshift = 0: shamt, sh[1:0], 0, Rm.
  - [11:0] when regshift = 1: Rs, 0, sh[1:0], 1, Rm.
  - RRX encodes as shamt 0, sh 11, bit4 0.
- MEM encoding:
  - [27:26] 01, [25] = ~in_imm, P = 1, U = 1, B = 0, W = 0, [20] L, Rn, Rd.
  - [11:0] is imm12 when immediate, otherwise shamt, sh, 0, Rm.
- B/BL encoding: [27:25] 101, [24] = in_class[0], [23:0] imm24.
- Illegal descriptors (accepted but not written; no address increment; err_count++ and err set):
  - cond = 1111;
  - regshift with RRX;
  - ROR with shamt 0 and regshift = 0;
  - MEM with regshift = 1;
  - MEM register offset with RRX.
- An illegal final descriptor while address < DEPTH does not cause DONE.
- Simultaneous start and finish: the state-appropriate one wins (start in IDLE/DONE, finish in LOAD).
- Reset mid-LOAD clears imem_we asynchronously. The in-flight write is dropped.

Test Plan:
- start; ADD R1,R2,#5 (class 00, cond E, I 1, cmd 4, Rn 2, Rd 1, immval 0x005) → imem_we one cycle later, addr 0, wdata 0xE2821005, word_count 1.
- SUBS R3,R4,R5 LSL #2 (I 0, cmd 2, S 1, shamt 2) → 0xE0543105. CMP R0,#0 with in_s 0 → 0xE3500000 (S forced).
- LDR R0,[R1,#4] → 0xE5910004. STR R0,[R1,#8] → 0xE5810008. BL cond E imm24 0x000010 → 0xEB000010. Addresses are consecutive.
- DP with regshift 1, shtype RRX; then cond F → no writes, err_count 2, err 1, address unchanged; the next legal descriptor is written at the same address.
- DEPTH = 4, five back-to-back valids → writes at 0..3, in_ready low after the 4th accept, done = 1, fifth not accepted. start → word_count 0, writes resume at 0.
- Mid-stream reset low with imem_we pending → imem_we 0 immediately; all outputs at reset values; in_ready stays 0 until start.
